// File: rtl/edge_tick_timer.sv
// Purpose: synchronise div_clk, emit one tick per rising edge, count ticks down from load_value.
// Latency: tick is high 3 inclk edges after div_clk is first sampled high; FSM outputs are registered.
// Backpressure: none; start is taken only in IDLE and stop only in RUN, other requests are dropped.
module edge_tick_timer (
    input  logic        inclk,
    input  logic        reset,
    input  logic        div_clk,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] load_value,
    output logic        tick,
    output logic        busy,
    output logic        done,
    output logic [15:0] count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic        busy_q, done_q;

    logic        sync1_q, sync2_q;
    // prev_q is the last trusted sync2 value; it is forced high until sync2
    // carries a real post-reset sample, so a level that is already high at
    // reset release is never mistaken for a rising edge.
    logic        prev_q;
    logic        vld1_q, vld2_q;
    logic        tick_q;
    logic        tick_d;

    assign tick_d = vld2_q & sync2_q & ~prev_q;

    // Synchroniser, sample-validity pipeline and registered edge detector.
    always_ff @(posedge inclk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            prev_q  <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= div_clk;
            sync2_q <= sync1_q;
            vld1_q  <= 1'b1;
            vld2_q  <= vld1_q;
            prev_q  <= vld2_q ? sync2_q : 1'b1;
            tick_q  <= tick_d;
        end
    end

    // FSM state, count and registered status outputs.
    always_ff @(posedge inclk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    // Next-state and count update; the counted tick is the registered one.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (load_value != 16'd0) begin
                        count_d = load_value;
                        state_d = RUN;
                    end else begin
                        count_d = 16'd0;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (tick_q && (count_q != 16'd0)) begin
                    count_d = count_q - 16'd1;
                    if (count_q == 16'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tick  = tick_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;

endmodule

// File: tb/tb_edge_tick_timer.sv
// Directed bench for edge_tick_timer: tick latency, countdown, zero load,
// ignored start, stop abort and final-tick race, reset mid-run with div_clk high.
// Inputs change 1 ns after each rising edge; outputs are sampled at that point.
module tb_edge_tick_timer;

    logic        inclk;
    logic        reset;
    logic        div_clk;
    logic        start;
    logic        stop;
    logic [15:0] load_value;
    logic        tick;
    logic        busy;
    logic        done;
    logic [15:0] count;

    int errors = 0;
    int checks = 0;

    edge_tick_timer dut (
        .inclk      (inclk),
        .reset      (reset),
        .div_clk    (div_clk),
        .start      (start),
        .stop       (stop),
        .load_value (load_value),
        .tick       (tick),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    initial inclk = 1'b0;
    always #5 inclk = ~inclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge inclk);
        #1;
    endtask

    // One full div_clk period: 4 cycles high, 4 low. Any RUN decrement caused
    // by the rise is visible once this returns.
    task automatic pulse_div();
        div_clk = 1'b1;
        repeat (4) step();
        div_clk = 1'b0;
        repeat (4) step();
    endtask

    // div_clk pattern for the latency test: 9 cycles low, 9 high, repeating.
    function automatic logic dv(input int j);
        if (j < 0) return 1'b0;
        return ((j / 9) % 2) == 1;
    endfunction

    initial begin
        int ticks;
        reset      = 1'b1;
        div_clk    = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        load_value = 16'd0;

        // Reset state
        repeat (3) step();
        check("rst_tick", tick, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        reset = 1'b0;
        repeat (5) step();
        check("idle_tick", tick, 0);

        // Tick latency: value set after edge j shows as tick after edge j+3
        ticks = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            check($sformatf("lat_tick_%0d", i), tick, (dv(i-3) && !dv(i-4)) ? 1 : 0);
            if (tick) ticks++;
            div_clk = dv(i);
        end
        check("lat_total", ticks, 4);
        repeat (6) step();

        // Normal countdown from 3
        load_value = 16'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        check("cd_busy0", busy, 1);
        check("cd_count0", count, 3);
        check("cd_done0", done, 0);
        pulse_div();
        check("cd_count1", count, 2);
        pulse_div();
        check("cd_count2", count, 1);
        check("cd_busy2", busy, 1);
        div_clk = 1'b1;
        repeat (3) step();
        check("cd_tick3", tick, 1);
        check("cd_count_pre", count, 1);
        step();
        check("cd_count3", count, 0);
        check("cd_done3", done, 1);
        check("cd_busy3", busy, 0);
        step();
        check("cd_done_end", done, 0);
        check("cd_count_end", count, 0);
        div_clk = 1'b0;
        repeat (4) step();

        // Zero load
        load_value = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("zl_done", done, 1);
        check("zl_busy", busy, 0);
        check("zl_count", count, 0);
        step();
        check("zl_done_end", done, 0);
        check("zl_busy_end", busy, 0);

        // Ignored start in RUN, then stop abort, then stop ignored in IDLE
        load_value = 16'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        check("is_count0", count, 5);
        pulse_div();
        check("is_count1", count, 4);
        load_value = 16'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        check("is_count_ign", count, 4);
        check("is_busy_ign", busy, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_count", count, 4);
        check("ab_done", done, 0);
        pulse_div();
        check("ab_count_idle", count, 4);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("idle_stop_count", count, 4);
        check("idle_stop_done", done, 0);

        // Stop racing the final tick at count=1
        load_value = 16'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("race_count0", count, 1);
        div_clk = 1'b1;
        repeat (3) step();
        check("race_tick", tick, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("race_busy", busy, 0);
        check("race_count", count, 1);
        check("race_done", done, 0);
        step();
        check("race_done_late", done, 0);
        div_clk = 1'b0;
        repeat (4) step();

        // Reset mid-run at count=5 with div_clk high through release
        load_value = 16'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        check("mr_count0", count, 5);
        div_clk = 1'b1;
        reset = 1'b1;
        step();
        check("mr_tick", tick, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_count", count, 0);
        repeat (2) step();
        reset = 1'b0;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tick) ticks++;
            check($sformatf("mr_busy_rel_%0d", i), busy, 0);
        end
        check("mr_no_tick", ticks, 0);
        div_clk = 1'b0;
        repeat (4) step();
        check("mr_tick_fall", tick, 0);
        div_clk = 1'b1;
        repeat (2) step();
        check("mr_tick_e2", tick, 0);
        step();
        check("mr_tick_e3", tick, 1);
        step();
        check("mr_tick_e4", tick, 0);
        check("mr_count_end", count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/edge_tick_timer.md
EDGE_TICK_TIMER -- requirements
Module: edge_tick_timer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 inclk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the inclk rising edge.
REQ-004 div_clk  input  1  divided clock from the upstream clock divider; treated as asynchronous data, never used as a clock.
REQ-005 start  input  1  request to begin a countdown; acted on only in IDLE.
REQ-006 stop  input  1  abort request; acted on only in RUN.
REQ-007 load_value  input  16  number of div_clk rising edges to count; sampled with start.
REQ-008 tick  output  1  one-inclk-cycle pulse per div_clk rising edge.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse when a countdown completes normally.
REQ-011 count  output  16  remaining edges in the current countdown.

Function
REQ-012 SHALL pass div_clk through a 2-flop synchronizer (sync1, then sync2) before any use.
REQ-013 SHALL register tick high for exactly one inclk cycle on each 0->1 transition of sync2. Tick latency: div_clk sampled high at edge E1 gives sync1=1 at E1, sync2=1 at E2, tick=1 after E3, and tick=0 after E4.
REQ-014 A div_clk level that is already high at reset release SHALL NOT produce a tick; only 0->1 transitions seen after reset count.
REQ-015 Tick generation SHALL run continuously in every FSM state.
REQ-016 FSM states SHALL be IDLE, RUN and DONE, all registered.
REQ-017 IDLE with start=1 and load_value!=0: count <= load_value, next state RUN.
REQ-018 IDLE with start=1 and load_value==0: count <= 0, next state DONE, with no wait for a tick.
REQ-019 RUN with tick=1 and stop=0: count <= count-1; when count==1, next state DONE.
REQ-020 RUN with stop=1: next state IDLE, count held, no done pulse; stop SHALL win over a simultaneous final tick.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-022 start SHALL be ignored in RUN and DONE; stop SHALL be ignored in IDLE and DONE.
REQ-023 busy SHALL equal (state==RUN), registered, with no combinational path from inputs.
REQ-024 count SHALL never wrap: no decrement occurs below 0, and count holds its last value in IDLE.
REQ-025 The tick counted in RUN SHALL be the registered tick output, so ticks arriving in the same cycle as start are not counted.

Reset
REQ-026 reset=1 SHALL force: state=IDLE; sync1=sync2=0; tick=0; busy=0; done=0; count=0.
REQ-027 reset asserted mid-RUN SHALL abort the countdown on the next edge with no done pulse; reset SHALL have priority over start, stop and tick.
REQ-028 Following reset deassertion, the first tick SHALL require an observed div_clk 0->1 transition (see REQ-014).

Verification
REQ-029 Tick latency: div_clk toggles every 9 inclk cycles -> exactly one tick per 18 cycles, 3 cycles after each div_clk rise, and none on falls.
REQ-030 Normal countdown: start with load_value=3 -> busy=1 next cycle; count goes 3,2,1,0 on successive ticks; done pulses once; busy=0 after the third tick.
REQ-031 Zero load: start with load_value=0 -> done=1 in the next cycle, busy never asserts, count=0.
REQ-032 Abort race: stop asserted in the same cycle as the final tick with count=1 -> IDLE, count=1, no done pulse.
REQ-033 Reset mid-run: reset asserted at count=5 with div_clk held high through release -> all outputs 0, and no tick until div_clk falls and rises again.
REQ-034 Ignored start: start pulsed during RUN with a different load_value -> no effect on count or state.
